audio_ctrl: RTL and testbench

// Sample-rate scheduler and buffer in front of the stereo sigma-delta audio DAC.
// CPU/DMA pushes packed stereo samples into a small FIFO through a valid/ready port.
// A programmable divider pops one sample per sample period and drives the DAC's
// 8-bit unsigned data_left/data_right inputs.

---
 rtl/audio_ctrl.sv | 161 ++++++++++++++++
 tb/tb_audio_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_ctrl.sv
// Sample-rate scheduler and FIFO in front of the stereo sigma-delta DAC.
// Optional AUDIO_CTRL_VOLUME_EN adds a per-channel attenuation port.
module audio_ctrl #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        enable,
  input  logic [DIV_W-1:0]            div,
  input  logic                        mute,
`ifdef AUDIO_CTRL_VOLUME_EN
  input  logic [2:0]                  volume,
`endif
  input  logic [15:0]                 wr_data,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        refill,
  output logic                        underrun,
  input  logic                        underrun_clr,
  output logic [7:0]                  data_left,
  output logic [7:0]                  data_right
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] Full = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] Half = LW'(FIFO_DEPTH / 2);
  localparam logic [15:0] Midscale = 16'h8080;

  typedef enum logic [1:0] {StIdle, StPlay, StUnder} state_e;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [15:0]       sample_q, sample_d;
  logic              underrun_q, underrun_d;
  logic              refill_q, refill_d;
  logic [15:0]       mem [FIFO_DEPTH];
  logic              push, pop, flush, set_under, full, empty;

  assign full  = (level_q == Full);
  assign empty = (level_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pop       = 1'b0;
    flush     = 1'b0;
    set_under = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StPlay;
          cnt_d   = div;
        end
      end
      StPlay, StUnder: begin
        if (!enable) begin
          state_d = StIdle;
          flush   = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          cnt_d = div;
          if (empty) begin
            set_under = 1'b1;
            state_d   = StUnder;
          end else begin
            pop     = 1'b1;
            state_d = StPlay;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A push in the cycle that stops playback is dropped along with the flushed FIFO.
  assign push = wr_valid && !full && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    sample_d = sample_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      sample_d = Midscale;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        sample_d = mem[rd_ptr_q];
      end
      level_d = level_q + LW'(push) - LW'(pop);
    end
    underrun_d = set_under ? 1'b1 : (underrun_clr ? 1'b0 : underrun_q);
    refill_d   = enable && (level_d <= Half);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      sample_q   <= Midscale;
      underrun_q <= 1'b0;
      refill_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      sample_q   <= sample_d;
      underrun_q <= underrun_d;
      refill_q   <= refill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  assign wr_ready   = !full;
  assign fifo_level = level_q;
  assign refill     = refill_q;
  assign underrun   = underrun_q;

  logic [7:0] left_s, right_s;

`ifdef AUDIO_CTRL_VOLUME_EN
  // Attenuate around midscale so silence stays silent at every volume setting.
  function automatic logic [7:0] scale(input logic [7:0] s, input logic [2:0] v);
    logic signed [9:0] diff, res;
    diff = $signed({2'b00, s}) - 10'sd128;
    res  = (diff >>> v) + 10'sd128;
    if (res < 10'sd0)        return 8'h00;
    else if (res > 10'sd255) return 8'hFF;
    else                     return res[7:0];
  endfunction

  assign left_s  = scale(sample_q[15:8], volume);
  assign right_s = scale(sample_q[7:0], volume);
`else
  assign left_s  = sample_q[15:8];
  assign right_s = sample_q[7:0];
`endif

  assign data_left  = mute ? 8'h80 : left_s;
  assign data_right = mute ? 8'h80 : right_s;

endmodule

// File: tb/tb_audio_ctrl.sv
// Self-checking bench for audio_ctrl: expected samples are queued at push time
// and compared when the bench-computed sample tick is due.
module tb_audio_ctrl;

  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned DIV_W      = 16;

  logic             clk = 1'b0;
  logic             resetn;
  logic             enable;
  logic [DIV_W-1:0] div;
  logic             mute;
`ifdef AUDIO_CTRL_VOLUME_EN
  logic [2:0]       volume;
`endif
  logic [15:0]      wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic [4:0]       fifo_level;
  logic             refill;
  logic             underrun;
  logic             underrun_clr;
  logic [7:0]       data_left;
  logic [7:0]       data_right;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [15:0] sb [$];

  audio_ctrl #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .DIV_W     (DIV_W)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .enable      (enable),
    .div         (div),
    .mute        (mute),
`ifdef AUDIO_CTRL_VOLUME_EN
    .volume      (volume),
`endif
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .fifo_level  (fifo_level),
    .refill      (refill),
    .underrun    (underrun),
    .underrun_clr(underrun_clr),
    .data_left   (data_left),
    .data_right  (data_right)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_sample(input string tag);
    logic [15:0] exp;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp = sb.pop_front();
      check(tag, {16'h0, data_left, data_right}, {16'h0, exp});
    end
  endtask

  task automatic push_sample(input logic [15:0] d, input bit track);
    wr_valid = 1'b1;
    wr_data  = d;
    if (track) sb.push_back(d);
    step();
  endtask

  initial begin
    logic [15:0] exp;
    resetn = 1'b0; enable = 1'b0; div = '0; mute = 1'b0;
    wr_data = '0; wr_valid = 1'b0; underrun_clr = 1'b0;
`ifdef AUDIO_CTRL_VOLUME_EN
    volume = 3'd0;
`endif
    step(); step();
    resetn = 1'b1;
    repeat (20) step();
    check("rst_data",     {16'h0, data_left, data_right}, 32'h8080);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_level",    32'(fifo_level), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_refill",   32'(refill), 32'd0);

    // Prefill two samples, then play with a 4-cycle period.
    push_sample(16'h10F0, 1'b1);
    push_sample(16'h20E0, 1'b1);
    wr_valid = 1'b0;
    check("prefill_level", 32'(fifo_level), 32'd2);
    div = 16'd3; enable = 1'b1;
    step();
    repeat (3) step();
    check("pre_tick1", {16'h0, data_left, data_right}, 32'h8080);
    step();
    expect_sample("tick1");
    repeat (3) step();
    check("hold1", {16'h0, data_left, data_right}, 32'h10F0);
    step();
    expect_sample("tick2");
    repeat (3) step();
    check("no_underrun_yet", 32'(underrun), 32'd0);
    step();
    check("underrun_set",  32'(underrun), 32'd1);
    check("underrun_hold", {16'h0, data_left, data_right}, 32'h20E0);
    check("refill_low",    32'(refill), 32'd1);

    // Recovery from UNDER on the next tick.
    push_sample(16'h3344, 1'b1);
    wr_valid = 1'b0;
    repeat (3) step();
    expect_sample("recover");
    check("underrun_sticky", 32'(underrun), 32'd1);
    underrun_clr = 1'b1; div = 16'd100;
    step();
    underrun_clr = 1'b0;
    check("underrun_clr", 32'(underrun), 32'd0);
    step(); step();
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check("set_wins", 32'(underrun), 32'd1);

    // Flush on enable drop; the concurrent push is discarded.
    for (int i = 0; i < 5; i++) push_sample(16'h5000 + 16'(i), 1'b0);
    check("queued_level",  32'(fifo_level), 32'd5);
    check("queued_refill", 32'(refill), 32'd1);
    enable = 1'b0; wr_data = 16'hABCD;
    step();
    wr_valid = 1'b0;
    check("flush_level",  32'(fifo_level), 32'd0);
    check("flush_data",   {16'h0, data_left, data_right}, 32'h8080);
    check("flush_refill", 32'(refill), 32'd0);

    // Fill to capacity; the 17th push must not land.
    for (int i = 0; i < 16; i++) push_sample({8'(i) + 8'h01, 8'hFF - 8'(i)}, 1'b1);
    check("full_ready", 32'(wr_ready), 32'd0);
    check("full_level", 32'(fifo_level), 32'd16);
    push_sample(16'hDEAD, 1'b0);
    wr_valid = 1'b0;
    check("no_overflow", 32'(fifo_level), 32'd16);

    // div=0: one pop per cycle, mute mid-stream.
    div = 16'd0; enable = 1'b1;
    step();
    check("refill_high", 32'(refill), 32'd0);
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 5) begin
        exp = sb.pop_front();
        mute = 1'b1;
        #1;
        check("mute_data",  {16'h0, data_left, data_right}, 32'h8080);
        check("mute_level", 32'(fifo_level), 32'd10);
        mute = 1'b0;
        #1;
        check("unmute_data", {16'h0, data_left, data_right}, {16'h0, exp});
      end else begin
        expect_sample("div0_pop");
      end
    end
    step();
    check("drained_level", 32'(fifo_level), 32'd0);

    // Reset mid-play.
    push_sample(16'h1234, 1'b0);
    push_sample(16'h5678, 1'b0);
    wr_valid = 1'b0;
    resetn = 1'b0;
    step();
    check("mid_rst_data",     {16'h0, data_left, data_right}, 32'h8080);
    check("mid_rst_level",    32'(fifo_level), 32'd0);
    check("mid_rst_underrun", 32'(underrun), 32'd0);
    check("mid_rst_ready",    32'(wr_ready), 32'd1);
    check("mid_rst_refill",   32'(refill), 32'd0);
    enable = 1'b0;
    step();
    resetn = 1'b1;
    sb.delete();

`ifdef AUDIO_CTRL_VOLUME_EN
    push_sample(16'hFF00, 1'b0);
    wr_valid = 1'b0;
    enable = 1'b1;
    step();
    step();
    check("vol0", {16'h0, data_left, data_right}, 32'hFF00);
    volume = 3'd1;
    #1;
    check("vol1_left", 32'(data_left), 32'hBF);
    volume = 3'd2;
    #1;
    check("vol2_right", 32'(data_right), 32'h60);
    mute = 1'b1;
    #1;
    check("vol_mute", {16'h0, data_left, data_right}, 32'h8080);
    mute = 1'b0; volume = 3'd0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
